fmap_op_sequencer: RTL and testbench

//  Top control FSM of the feature-map core (8x8xC image buffer, 2x2 display window).
//  - Issues the op_ready/op_valid instruction handshake and decodes 4-bit op modes.
//  - Drives feature-map SRAM addressing for load (2048 B) and display reads.
//  - Owns origin/depth state; starts/waits on the filter engine (conv/median/sobel).

---
 rtl/fmap_op_sequencer_if.sv | 35 +++
 rtl/fmap_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fmap_op_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_op_sequencer_if.sv
// Op / load / display / engine handshake bundle of the feature-map sequencer.
// The sequencer connects through the slave modport; the surrounding core
// (or a testbench) drives it through the master modport.
interface fmap_op_sequencer_if;
    logic        i_op_valid;
    logic [3:0]  i_op_mode;
    logic        o_op_ready;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [10:0] o_sram_addr;
    logic        o_sram_wen;
    logic        o_sram_ren;
    logic        o_disp_valid;
    logic        o_eng_start;
    logic [1:0]  o_eng_mode;
    logic        i_eng_done;
    logic [2:0]  o_origin_x;
    logic [2:0]  o_origin_y;
    logic [5:0]  o_depth;
    logic        o_op_err;

    modport slave (
        input  i_op_valid, i_op_mode, i_in_valid, i_eng_done,
        output o_op_ready, o_in_ready, o_sram_addr, o_sram_wen, o_sram_ren,
               o_disp_valid, o_eng_start, o_eng_mode, o_origin_x, o_origin_y,
               o_depth, o_op_err
    );

    modport master (
        output i_op_valid, i_op_mode, i_in_valid, i_eng_done,
        input  o_op_ready, o_in_ready, o_sram_addr, o_sram_wen, o_sram_ren,
               o_disp_valid, o_eng_start, o_eng_mode, o_origin_x, o_origin_y,
               o_depth, o_op_err
    );
endinterface

// File: rtl/fmap_op_sequencer.sv
// Top control FSM of the feature-map core: op handshake and decode, SRAM
// addressing for image load and 2x2 window display, origin/depth state and
// filter-engine start/wait.
// Optional feature: define SEQ_PERF_CNT_EN to add the o_busy_cycles counter
// (cycles spent outside WAIT_OP); without it the port does not exist.
module fmap_op_sequencer #(
    parameter int FMAP_W = 8,
    parameter int FMAP_C = 32,
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    fmap_op_sequencer_if.slave bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] o_busy_cycles
`endif
);

    localparam int LOAD_BEATS = FMAP_W * FMAP_W * FMAP_C;
    localparam int POS_MAX    = FMAP_W - 2;
    localparam int DEPTH_MIN  = FMAP_C / 4;
    localparam int DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_WAIT_OP, S_LOAD, S_DISP, S_DRAIN, S_ENG
    } state_t;

    state_t              state, state_nxt;
    logic [10:0]         load_cnt;
    logic [7:0]          disp_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [2:0]          origin_x, origin_y;
    logic [5:0]          depth;
    logic [1:0]          eng_mode;
    logic                eng_start_q;
    logic                op_err_q;
    logic [RD_LAT-1:0]   rd_pipe;

    logic                op_accept;
    logic                load_last, disp_last, drain_last;
    logic [5:0]          disp_c;
    logic [2:0]          disp_x, disp_y;
    logic [10:0]         disp_addr;

    logic                op_ready, in_ready, sram_wen, sram_ren;
    logic [10:0]         sram_addr;

    assign op_accept  = (state == S_WAIT_OP) && bus.i_op_valid;
    assign load_last  = (load_cnt == 11'(LOAD_BEATS - 1));
    assign disp_last  = (disp_cnt == 8'(int'(depth) * 4 - 1));
    assign drain_last = (drain_cnt == DRAIN_W'(RD_LAT - 1));

    // Window read index: two low bits pick the pixel in the 2x2 window, the rest is the channel.
    assign disp_c    = disp_cnt[7:2];
    assign disp_x    = origin_x + {2'b00, disp_cnt[0]};
    assign disp_y    = origin_y + {2'b00, disp_cnt[1]};
    assign disp_addr = 11'(int'(disp_c) * FMAP_W * FMAP_W + int'(disp_y) * FMAP_W + int'(disp_x));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and per-state strobes/address.
    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        in_ready  = 1'b0;
        sram_wen  = 1'b0;
        sram_ren  = 1'b0;
        sram_addr = 11'd0;
        case (state)
            S_IDLE:  state_nxt = S_READY;
            S_READY: begin
                op_ready  = 1'b1;
                state_nxt = S_WAIT_OP;
            end
            S_WAIT_OP: begin
                if (bus.i_op_valid) begin
                    case (bus.i_op_mode)
                        4'd0:                state_nxt = S_LOAD;
                        4'd7:                state_nxt = S_DISP;
                        4'd8, 4'd9, 4'd10:   state_nxt = S_ENG;
                        default:             state_nxt = S_READY;
                    endcase
                end
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                sram_wen  = bus.i_in_valid;
                sram_addr = load_cnt;
                if (bus.i_in_valid && load_last) state_nxt = S_READY;
            end
            S_DISP: begin
                sram_ren  = 1'b1;
                sram_addr = disp_addr;
                if (disp_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (drain_last) state_nxt = S_READY;
            S_ENG:   if (bus.i_eng_done) state_nxt = S_READY;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, origin/depth, engine mode and the registered one-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            load_cnt    <= 11'd0;
            disp_cnt    <= 8'd0;
            drain_cnt   <= '0;
            origin_x    <= 3'd0;
            origin_y    <= 3'd0;
            depth       <= 6'(FMAP_C);
            eng_mode    <= 2'd0;
            eng_start_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            op_err_q    <= 1'b0;
            if (op_accept) begin
                case (bus.i_op_mode)
                    4'd0: load_cnt <= 11'd0;
                    4'd1: if (origin_x < 3'(POS_MAX)) origin_x <= origin_x + 3'd1;
                    4'd2: if (origin_x > 3'd0) origin_x <= origin_x - 3'd1;
                    4'd3: if (origin_y > 3'd0) origin_y <= origin_y - 3'd1;
                    4'd4: if (origin_y < 3'(POS_MAX)) origin_y <= origin_y + 3'd1;
                    4'd5: if (depth > 6'(DEPTH_MIN)) depth <= depth >> 1;
                    4'd6: if (depth < 6'(FMAP_C)) depth <= depth << 1;
                    4'd7: begin
                        disp_cnt  <= 8'd0;
                        drain_cnt <= '0;
                    end
                    4'd8, 4'd9, 4'd10: begin
                        eng_mode    <= 2'(bus.i_op_mode - 4'd8);
                        eng_start_q <= 1'b1;
                    end
                    default: op_err_q <= 1'b1;
                endcase
            end
            if (sram_wen)           load_cnt  <= load_cnt + 11'd1;
            if (state == S_DISP)    disp_cnt  <= disp_cnt + 8'd1;
            if (state == S_DRAIN)   drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    // Read-strobe delay line that qualifies the SRAM output RD_LAT cycles later.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= sram_ren;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Busy-cycle counter: every cycle not spent waiting for an op.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                o_busy_cycles <= 32'd0;
        else if (state != S_WAIT_OP) o_busy_cycles <= o_busy_cycles + 32'd1;
    end
`endif

    assign bus.o_op_ready   = op_ready;
    assign bus.o_in_ready   = in_ready;
    assign bus.o_sram_addr  = sram_addr;
    assign bus.o_sram_wen   = sram_wen;
    assign bus.o_sram_ren   = sram_ren;
    assign bus.o_disp_valid = rd_pipe[RD_LAT-1];
    assign bus.o_eng_start  = eng_start_q;
    assign bus.o_eng_mode   = eng_mode;
    assign bus.o_origin_x   = origin_x;
    assign bus.o_origin_y   = origin_y;
    assign bus.o_depth      = depth;
    assign bus.o_op_err     = op_err_q;

endmodule

// File: tb/tb_fmap_op_sequencer.sv
// Testbench for fmap_op_sequencer: directed op sequences, with expected SRAM
// write/read addresses queued at issue time and popped by an independent monitor.
module tb_fmap_op_sequencer;

    localparam int READY_LIMIT = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fmap_op_sequencer_if bus();
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] busy_cycles;
`endif

    fmap_op_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .o_busy_cycles (busy_cycles)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [10:0] exp_wr[$];
    logic [10:0] exp_rd[$];
    int rd_cnt = 0;
    int disp_valid_cnt = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every write/read strobe pops the next expected address.
    always @(negedge clk) begin
        if (bus.o_sram_wen) begin
            checkOutput("wen_on_beat", int'(bus.i_in_valid), 1);
            if (exp_wr.size() == 0) checkOutput("wr_extra", 1, 0);
            else checkOutput("wr_addr", int'(bus.o_sram_addr), int'(exp_wr.pop_front()));
        end
        if (bus.o_sram_ren) begin
            rd_cnt++;
            if (exp_rd.size() == 0) checkOutput("rd_extra", 1, 0);
            else checkOutput("rd_addr", int'(bus.o_sram_addr), int'(exp_rd.pop_front()));
        end
        if (bus.o_disp_valid) disp_valid_cnt++;
    end

    task automatic waitReady(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.o_op_ready && cycles < READY_LIMIT);
        if (!bus.o_op_ready) checkOutput("ready_timeout", 0, 1);
    endtask

    // Issue an op; ready_seen means op_ready was already observed at this negedge.
    task automatic applyStimulus(input logic [3:0] op, input bit ready_seen);
        int cyc;
        if (!ready_seen) waitReady(cyc);
        bus.i_op_valid = 1'b1;
        bus.i_op_mode  = op;
        @(posedge clk);
        @(posedge clk);
        #1 bus.i_op_valid = 1'b0;
    endtask

    initial begin
        int cyc, pulses, first_idx, beats, errs;
        bus.i_op_valid = 1'b0;
        bus.i_op_mode  = 4'd0;
        bus.i_in_valid = 1'b0;
        bus.i_eng_done = 1'b0;

        // Reset values and the single op_ready pulse after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_op_ready", int'(bus.o_op_ready), 0);
        checkOutput("rst_addr", int'(bus.o_sram_addr), 0);
        checkOutput("rst_origin_x", int'(bus.o_origin_x), 0);
        checkOutput("rst_origin_y", int'(bus.o_origin_y), 0);
        checkOutput("rst_depth", int'(bus.o_depth), 32);
        checkOutput("rst_in_ready", int'(bus.o_in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        first_idx = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.o_op_ready) begin
                pulses++;
                if (first_idx == 0) first_idx = i;
            end
        end
        checkOutput("ready_pulses", pulses, 1);
        checkOutput("ready_cycle", first_idx, 2);

        // LOAD: sequencer is in WAIT_OP, so a single-edge op pulse is accepted.
        for (int i = 0; i < 2048; i++) exp_wr.push_back(11'(i));
        @(posedge clk);
        #1 bus.i_op_valid = 1'b1;
        bus.i_op_mode = 4'd0;
        @(posedge clk);
        #1 bus.i_op_valid = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 2048 && cyc < 8000) begin
            bus.i_in_valid = (cyc % 3 != 2);
            @(posedge clk);
            if (bus.i_in_valid) beats++;
            #1;
            cyc++;
        end
        bus.i_in_valid = 1'b0;
        checkOutput("load_beats", beats, 2048);
        @(negedge clk);
        checkOutput("load_ready_next", int'(bus.o_op_ready), 1);
        checkOutput("load_in_ready_drop", int'(bus.o_in_ready), 0);
        checkOutput("load_wr_left", exp_wr.size(), 0);

        // Shifts with saturation at both bounds.
        applyStimulus(4'd1, 1'b1);
        for (int i = 2; i <= 7; i++) begin
            applyStimulus(4'd1, 1'b0);
            if (i == 6) checkOutput("shr6_x", int'(bus.o_origin_x), 6);
        end
        checkOutput("shr7_x", int'(bus.o_origin_x), 6);
        for (int i = 0; i < 7; i++) applyStimulus(4'd4, 1'b0);
        checkOutput("shd7_y", int'(bus.o_origin_y), 6);
        checkOutput("shd7_x", int'(bus.o_origin_x), 6);
        for (int i = 0; i < 8; i++) applyStimulus(4'd2, 1'b0);
        checkOutput("shl8_x", int'(bus.o_origin_x), 0);
        for (int i = 0; i < 6; i++) applyStimulus(4'd3, 1'b0);
        checkOutput("shu6_y", int'(bus.o_origin_y), 0);

        // Scale down to the floor, then display the 2x2 window over 8 channels.
        applyStimulus(4'd5, 1'b0);
        checkOutput("scale_16", int'(bus.o_depth), 16);
        applyStimulus(4'd5, 1'b0);
        checkOutput("scale_8", int'(bus.o_depth), 8);
        applyStimulus(4'd5, 1'b0);
        checkOutput("scale_sat8", int'(bus.o_depth), 8);
        for (int c = 0; c < 8; c++)
            for (int y = 0; y < 2; y++)
                for (int x = 0; x < 2; x++) exp_rd.push_back(11'(c * 64 + y * 8 + x));
        rd_cnt = 0;
        disp_valid_cnt = 0;
        applyStimulus(4'd7, 1'b0);
        waitReady(cyc);
        checkOutput("disp_cycles", cyc, 34);
        checkOutput("disp_reads", rd_cnt, 32);
        checkOutput("disp_valid_cnt", disp_valid_cnt, 32);
        checkOutput("disp_rd_left", exp_rd.size(), 0);

        // Median engine held off for 100 cycles.
        applyStimulus(4'd9, 1'b1);
        @(negedge clk);
        checkOutput("eng_start", int'(bus.o_eng_start), 1);
        checkOutput("eng_mode_med", int'(bus.o_eng_mode), 1);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_op_ready || bus.o_eng_mode != 2'd1 || bus.o_eng_start) errs++;
        end
        checkOutput("eng_wait_stable", errs, 0);
        @(posedge clk);
        #1 bus.i_eng_done = 1'b1;
        @(posedge clk);
        #1 bus.i_eng_done = 1'b0;
        waitReady(cyc);
        checkOutput("eng_done_ready", cyc, 1);

        // Conv engine with done in the start cycle.
        applyStimulus(4'd8, 1'b1);
        bus.i_eng_done = 1'b1;
        @(negedge clk);
        checkOutput("eng_start_conv", int'(bus.o_eng_start), 1);
        checkOutput("eng_mode_conv", int'(bus.o_eng_mode), 0);
        @(posedge clk);
        #1 bus.i_eng_done = 1'b0;
        waitReady(cyc);
        checkOutput("eng_fast_ready", cyc, 1);

        // Illegal op.
        applyStimulus(4'd13, 1'b1);
        @(negedge clk);
        checkOutput("op_err_pulse", int'(bus.o_op_err), 1);
        checkOutput("err_origin_x", int'(bus.o_origin_x), 0);
        checkOutput("err_origin_y", int'(bus.o_origin_y), 0);
        checkOutput("err_depth", int'(bus.o_depth), 8);
        @(negedge clk);
        checkOutput("op_err_clear", int'(bus.o_op_err), 0);

        // Reset in the middle of a display.
        for (int c = 0; c < 8; c++)
            for (int y = 0; y < 2; y++)
                for (int x = 0; x < 2; x++) exp_rd.push_back(11'(c * 64 + y * 8 + x));
        bus.i_op_valid = 1'b1;
        bus.i_op_mode  = 4'd7;
        @(posedge clk);
        #1 bus.i_op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 exp_rd.delete();
        @(negedge clk);
        checkOutput("mid_rst_ren", int'(bus.o_sram_ren), 0);
        checkOutput("mid_rst_disp_valid", int'(bus.o_disp_valid), 0);
        checkOutput("mid_rst_addr", int'(bus.o_sram_addr), 0);
        checkOutput("mid_rst_depth", int'(bus.o_depth), 32);
        checkOutput("mid_rst_op_ready", int'(bus.o_op_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        waitReady(cyc);
        checkOutput("post_rst_ready", cyc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
